// File: rtl/mem_responder.sv
// mem_responder: 2^ADDR_WIDTH x DATA_WIDTH word store with a four-phase
// ready handshake. Define MEM_ADDR_CHECK_EN to reject out-of-range addresses.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Mem_enable512x32,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic [31:0]           MAR_address,
    input  logic [DATA_WIDTH-1:0] Mem_data_to_chip,
    output logic [DATA_WIDTH-1:0] Mem_to_datapath,
    output logic                  Mem_ready,
    output logic                  Mem_busy,
    output logic                  Mem_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [2:0] CNT_INIT =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] rdata;

    logic                  req_valid;
    logic                  addr_bad;
    logic                  do_access;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  acc_wr;

    assign req_valid = Mem_enable512x32 & (Mem_Read ^ Mem_Write);

`ifdef MEM_ADDR_CHECK_EN
    logic err_q;
    assign addr_bad = |MAR_address[31:ADDR_WIDTH];
`else
    logic unused_upper;
    assign addr_bad     = 1'b0;
    assign unused_upper = ^MAR_address[31:ADDR_WIDTH];
`endif

    // In IDLE the access (WAIT_STATES=0) uses the live inputs,
    // otherwise the values captured at the accepting edge.
    assign acc_addr = (state == ST_IDLE) ? MAR_address[ADDR_WIDTH-1:0]
                                         : addr_q;
    assign acc_data = (state == ST_IDLE) ? Mem_data_to_chip : data_q;
    assign acc_wr   = (state == ST_IDLE) ? Mem_Write : wr_q;

    // The access happens on the edge that enters ACK, unless rejected
    assign do_access = !clear
                     && (state != ST_ACK)
                     && (next_state == ST_ACK)
                     && !((state == ST_IDLE) && addr_bad);

    // State register; clear dominates everything
    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept, wait/abort, four-phase release
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (addr_bad || (WAIT_STATES == 0)) begin
                        next_state = ST_ACK;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!Mem_enable512x32) begin
                    next_state = ST_IDLE;
                end else if (cnt == 3'd0) begin
                    next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!Mem_Read && !Mem_Write) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        Mem_ready = (state == ST_ACK);
        Mem_busy  = (state == ST_WAIT);
`ifdef MEM_ADDR_CHECK_EN
        Mem_error = (state == ST_ACK) && err_q;
`else
        Mem_error = 1'b0;
`endif
    end

    // Request capture, wait counter and registered read data
    always_ff @(posedge Clock) begin
        if (clear) begin
            cnt    <= 3'd0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            rdata  <= '0;
        end else begin
            if ((state == ST_IDLE) && req_valid) begin
                cnt    <= CNT_INIT;
                addr_q <= MAR_address[ADDR_WIDTH-1:0];
                data_q <= Mem_data_to_chip;
                wr_q   <= Mem_Write;
            end else if ((state == ST_WAIT) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (do_access && !acc_wr) begin
                rdata <= mem[acc_addr];
            end
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    // Error flag captured at accept, meaningful only while in ACK
    always_ff @(posedge Clock) begin
        if (clear) begin
            err_q <= 1'b0;
        end else if ((state == ST_IDLE) && req_valid) begin
            err_q <= addr_bad;
        end
    end
`endif

    // Storage write port; contents survive clear
    always_ff @(posedge Clock) begin
        if (do_access && acc_wr) begin
            mem[acc_addr] <= acc_data;
        end
    end

    assign Mem_to_datapath = rdata;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, word-address width (512 words).
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..7, extra cycles per access.
REQ-004 SHALL have port Clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port clear  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port Mem_enable512x32  in  1  request qualifier.
REQ-007 SHALL have port Mem_Read  in  1  read request.
REQ-008 SHALL have port Mem_Write  in  1  write request.
REQ-009 SHALL have port MAR_address  in  32  word address from MAR.
REQ-010 SHALL have port Mem_data_to_chip  in  DATA_WIDTH  write data from MDR.
REQ-011 SHALL have port Mem_to_datapath  out  DATA_WIDTH  registered read data to MDR.
REQ-012 SHALL have port Mem_ready  out  1  access complete, held until request dropped.
REQ-013 SHALL have port Mem_busy  out  1  high while access in progress.
REQ-014 SHALL have port Mem_error  out  1  access rejected (see Configuration).

Function
REQ-015 SHALL hold a 2^ADDR_WIDTH x DATA_WIDTH storage array, 0 wait-free internal read.
REQ-016 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-017 In IDLE, valid request = Mem_enable512x32 & (Mem_Read XOR Mem_Write); SHALL latch address, write data, op at that edge.
REQ-018 Mem_Read and Mem_Write both high in IDLE SHALL be ignored (stay IDLE, no access).
REQ-019 Valid request, WAIT_STATES=0: IDLE->ACK same edge; else IDLE->WAIT, counter loaded WAIT_STATES-1.
REQ-020 WAIT SHALL decrement counter each cycle; at 0 go ACK; Mem_busy=1 throughout WAIT.
REQ-021 Access SHALL be performed on edge entering ACK: write commits latched data; read loads Mem_to_datapath.
REQ-022 Mem_ready SHALL rise exactly WAIT_STATES+1 edges after accepting edge counted from accept (N=0: after accept edge).
REQ-023 ACK SHALL hold Mem_ready=1 until Mem_Read and Mem_Write both low, then ->IDLE next edge (four-phase).
REQ-024 Mem_enable512x32 low during WAIT SHALL abort: ->IDLE, no write, Mem_to_datapath unchanged.
REQ-025 Mem_to_datapath SHALL hold last read value through writes and idle cycles.
REQ-026 Address/data changes after accept SHALL not affect the access in flight.
REQ-027 Without address check, only MAR_address[ADDR_WIDTH-1:0] used; upper bits ignored (wrap).

Reset
REQ-028 clear high at an edge SHALL force IDLE; Mem_ready=0, Mem_busy=0, Mem_error=0, Mem_to_datapath=0.
REQ-029 clear mid-WAIT SHALL cancel access with no write; storage array contents not cleared.
REQ-030 clear SHALL dominate any simultaneous request.

Configuration
REQ-031 Macro MEM_ADDR_CHECK_EN defined: request with any MAR_address[31:ADDR_WIDTH] nonzero SHALL go to ACK with Mem_error=1, no write, Mem_to_datapath unchanged; Mem_error clears leaving ACK.
REQ-032 MEM_ADDR_CHECK_EN undefined: Mem_error SHALL be tied 0 and REQ-027 wrap applies.

Verification
REQ-033 WAIT_STATES=1: write 0x12345678 to 0x010, drop; read 0x010 -> Mem_ready 2 edges after accept, Mem_to_datapath=0x12345678.
REQ-034 WAIT_STATES=0: read 0x1FF after writing 0xDEADBEEF -> Mem_ready after accept edge, data 0xDEADBEEF; held ready until Mem_Read low.
REQ-035 Read and Write both high at 0x020 -> no Mem_busy/Mem_ready; later read 0x020 returns prior contents.
REQ-036 Write 0xAAAA5555 to 0x030, drop enable in WAIT (WAIT_STATES=3) -> IDLE, read 0x030 returns old value; clear mid-WAIT likewise no write.
REQ-037 Address 0x00000210: with MEM_ADDR_CHECK_EN -> Mem_error=1, Mem_ready=1, 0x010 unchanged; without -> access hits word 0x010.
